// File: rtl/stump_shift_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stump_shift_seq: drives an external 1-bit Stump shifter once per cycle to
// give a count-controlled shift. Optional abort port: STUMP_SHIFT_SEQ_ABORT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module stump_shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef STUMP_SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic [WIDTH-1:0] operand_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sh_operand,
  output logic [1:0]       sh_op,
  output logic             sh_c_in,
  input  logic [WIDTH-1:0] sh_result,
  input  logic             sh_c_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic               carry_q, carry_d;
  logic [1:0]         op_q,    op_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               abort_w;

`ifdef STUMP_SHIFT_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      carry_q <= 1'b0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    carry_d = carry_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          work_d  = operand_in;
          carry_d = c_in;
          op_d    = op_in;
          cnt_d   = count_in;
          state_d = ((count_in == '0) || (op_in == 2'b00)) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Abort wins over the final step and leaves the partial value in place.
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          work_d  = sh_result;
          carry_d = sh_c_out;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sh_operand = work_q;
  assign sh_op      = op_q;
  assign sh_c_in    = carry_q;
  assign result     = work_q;
  assign c_out      = carry_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_stump_shift_seq.sv
`default_nettype none
// Directed bench for stump_shift_seq with a behavioural 1-bit Stump shifter.
module tb_stump_shift_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic [3:0]  count_in = 4'd0;
  logic [15:0] operand_in = 16'h0;
  logic        c_in = 1'b0;
  logic [15:0] sh_operand, sh_result, result;
  logic [1:0]  sh_op;
  logic        sh_c_in, sh_c_out, busy, done, c_out;
`ifdef STUMP_SHIFT_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stump_shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef STUMP_SHIFT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .op_in(op_in), .count_in(count_in),
    .operand_in(operand_in), .c_in(c_in),
    .sh_operand(sh_operand), .sh_op(sh_op), .sh_c_in(sh_c_in),
    .sh_result(sh_result), .sh_c_out(sh_c_out),
    .busy(busy), .done(done), .result(result), .c_out(c_out)
  );

  // Shifter environment: ASR, ROR, RRC by one position.
  always_comb begin
    sh_result = sh_operand;
    sh_c_out  = sh_c_in;
    case (sh_op)
      2'b01: begin sh_result = {sh_operand[15], sh_operand[15:1]}; sh_c_out = sh_operand[0]; end
      2'b10: begin sh_result = {sh_operand[0],  sh_operand[15:1]}; sh_c_out = sh_operand[0]; end
      2'b11: begin sh_result = {sh_c_in,        sh_operand[15:1]}; sh_c_out = sh_operand[0]; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive a request through edge E0; returns sampled just after E0.
  task automatic launch(input logic [1:0] op, input logic [3:0] cnt,
                        input logic [15:0] opd, input logic cin);
    op_in = op; count_in = cnt; operand_in = opd; c_in = cin; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({busy, done, result, c_out, sh_operand, sh_op, sh_c_in} !== 37'd0) begin
      bad++; $display("FAIL reset_state: got busy=%b done=%b result=%h c=%b sh=%h/%b/%b, want all 0",
                      busy, done, result, c_out, sh_operand, sh_op, sh_c_in);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ror();
    launch(2'b10, 4'd4, 16'h0001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL ror_busy cycle %0d: got busy=%b done=%b, want 1/0", i, busy, done);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || result !== 16'h1000 || c_out !== 1'b0) begin
      bad++; $display("FAIL ror_done: got done=%b busy=%b result=%h c=%b, want 1/1/1000/0",
                      done, busy, result, c_out);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h1000 || c_out !== 1'b0) begin
      bad++; $display("FAIL ror_hold: got done=%b busy=%b result=%h c=%b, want 0/0/1000/0",
                      done, busy, result, c_out);
    end
  endtask

  task automatic test_asr();
    launch(2'b01, 4'd3, 16'h8000, 1'b0);
    total++;
    if (sh_operand !== 16'h8000 || sh_op !== 2'b01) begin
      bad++; $display("FAIL asr_load: got sh_operand=%h sh_op=%b, want 8000/01", sh_operand, sh_op);
    end
    tick();
    total++;
    if (sh_operand !== 16'hC000) begin
      bad++; $display("FAIL asr_step1: got sh_operand=%h, want c000", sh_operand);
    end
    tick(); tick();
    total++;
    if (done !== 1'b1 || result !== 16'hF000 || c_out !== 1'b0) begin
      bad++; $display("FAIL asr_done: got done=%b result=%h c=%b, want 1/f000/0", done, result, c_out);
    end
    tick();
  endtask

  task automatic test_rrc();
    launch(2'b11, 4'd2, 16'h0001, 1'b0);
    tick();
    total++;
    if (sh_operand !== 16'h0000 || sh_c_in !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL rrc_step1: got %h c=%b done=%b, want 0000 c=1 done=0", sh_operand, sh_c_in, done);
    end
    tick();
    total++;
    if (done !== 1'b1 || result !== 16'h8000 || c_out !== 1'b0) begin
      bad++; $display("FAIL rrc_done: got done=%b result=%h c=%b, want 1/8000/0", done, result, c_out);
    end
    tick();
  endtask

  task automatic test_zero();
    launch(2'b10, 4'd0, 16'h1234, 1'b1);
    total++;
    if (done !== 1'b1 || result !== 16'h1234 || c_out !== 1'b1) begin
      bad++; $display("FAIL zero_count: got done=%b result=%h c=%b, want 1/1234/1", done, result, c_out);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_idle: got done=%b busy=%b, want 0/0", done, busy);
    end
    launch(2'b00, 4'd5, 16'h1234, 1'b1);
    total++;
    if (done !== 1'b1 || result !== 16'h1234 || c_out !== 1'b1) begin
      bad++; $display("FAIL none_op: got done=%b result=%h c=%b, want 1/1234/1", done, result, c_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int edges;
    op_in = 2'b10; count_in = 4'd15; operand_in = 16'h0001; c_in = 1'b0; start = 1'b1;
    tick();
    // Keep start high with different inputs; SHIFT must ignore them.
    op_in = 2'b01; count_in = 4'd1; operand_in = 16'h8000; c_in = 1'b1;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      edges = k;
      if (done === 1'b1) break;
    end
    total++;
    if (edges !== 15 || done !== 1'b1) begin
      bad++; $display("FAIL b2b_latency: got done after %0d edges (done=%b), want 15", edges, done);
    end
    total++;
    if (result !== 16'h0002 || c_out !== 1'b0) begin
      bad++; $display("FAIL b2b_result: got result=%h c=%b, want 0002/0", result, c_out);
    end
    tick();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || sh_operand !== 16'h8000 || sh_op !== 2'b01 || sh_c_in !== 1'b1) begin
      bad++; $display("FAIL b2b_reload: got busy=%b done=%b sh=%h/%b/%b, want 1/0/8000/01/1",
                      busy, done, sh_operand, sh_op, sh_c_in);
    end
    start = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || result !== 16'hC000 || c_out !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got done=%b result=%h c=%b, want 1/c000/0", done, result, c_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    launch(2'b10, 4'd10, 16'h0001, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result, c_out, sh_operand, sh_op, sh_c_in} !== 37'd0) begin
      bad++; $display("FAIL reset_mid: got busy=%b done=%b result=%h c=%b sh=%h/%b/%b, want all 0",
                      busy, done, result, c_out, sh_operand, sh_op, sh_c_in);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_no_done: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

`ifdef STUMP_SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    launch(2'b10, 4'd10, 16'h0001, 1'b0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h2000 || c_out !== 1'b0) begin
      bad++; $display("FAIL abort_partial: got busy=%b done=%b result=%h c=%b, want 0/0/2000/0",
                      busy, done, result, c_out);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done=%b, want 0", done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ror();
    test_asr();
    test_rrc();
    test_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef STUMP_SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
